// File: rtl/ant_pkg.sv
// rtl/ant_pkg.sv - shared move codes, FSM states and pheromone masking helper
package ant_pkg;

    typedef enum logic [1:0] {
        MOVE_HALT    = 2'b00,
        MOVE_RIGHT   = 2'b01,
        MOVE_LEFT    = 2'b10,
        MOVE_FORWARD = 2'b11
    } move_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Applied per pheromone bit so it works for any PH_WIDTH.
    function automatic logic ph_keep(input logic ph_bit, input logic budget_ok);
        return ph_bit & budget_ok;
    endfunction

endpackage

// File: rtl/ant_rr_pick.sv
// rtl/ant_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module ant_rr_pick #(
    parameter int N_ANTS = 4
) (
    input  logic [N_ANTS-1:0]         req,
    input  logic [$clog2(N_ANTS)-1:0] rr_ptr,
    output logic                      any,
    output logic [$clog2(N_ANTS)-1:0] idx
);
    localparam int IW = $clog2(N_ANTS);

    assign any = |req;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        for (int k = N_ANTS - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % N_ANTS;
            if (req[j[IW-1:0]]) idx = IW'(j);
        end
    end

endmodule

// File: rtl/ant_colony_arbiter.sv
// rtl/ant_colony_arbiter.sv - round-robin arbiter sharing the world actuator port
module ant_colony_arbiter
    import ant_pkg::*;
#(
    parameter int N_ANTS      = 4,
    parameter int PH_WIDTH    = 2,
    parameter int STALL_LIMIT = 16,
    parameter int PH_BUDGET   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_ANTS-1:0]            req,
    input  logic [2*N_ANTS-1:0]          move_in,
    input  logic [PH_WIDTH*N_ANTS-1:0]   ph_in,
    input  logic                         ph_refill,
    output logic [N_ANTS-1:0]            gnt,
    output logic                         world_valid,
    input  logic                         world_ready,
    output logic [$clog2(N_ANTS)-1:0]    world_ant,
    output logic [1:0]                   world_move,
    output logic [PH_WIDTH-1:0]          world_ph,
    output logic [N_ANTS-1:0]            stalled,
    output logic                         ph_empty
);
    localparam int IW = $clog2(N_ANTS);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int BW = $clog2(PH_BUDGET + 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       world_ant_q, world_ant_d;
    logic [1:0]          world_move_q, world_move_d;
    logic [PH_WIDTH-1:0] world_ph_q, world_ph_d;
    logic [BW-1:0]       budget_q, budget_d;

    logic                pick_any;
    logic [IW-1:0]       pick_idx;
    logic [PH_WIDTH-1:0] ph_masked;
    logic                hs;

    ant_rr_pick #(.N_ANTS(N_ANTS)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign world_valid = (state_q == ST_ISSUE);
    assign world_ant   = world_ant_q;
    assign world_move  = world_move_q;
    assign world_ph    = world_ph_q;
    assign ph_empty    = (budget_q == '0);
    assign hs          = world_valid && world_ready;

    always_comb begin
        gnt = '0;
        if (hs) gnt[world_ant_q] = 1'b1;
    end

    // Masking is frozen at latch time; a later refill cannot unmask the transfer.
    always_comb begin
        ph_masked = '0;
        for (int b = 0; b < PH_WIDTH; b++) begin
            ph_masked[b] = ph_keep(ph_in[int'(pick_idx)*PH_WIDTH + b], budget_q != '0);
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        world_ant_d  = world_ant_q;
        world_move_d = world_move_q;
        world_ph_d   = world_ph_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d      = ST_ISSUE;
                    world_ant_d  = pick_idx;
                    world_move_d = move_in[2*int'(pick_idx) +: 2];
                    world_ph_d   = ph_masked;
                end
            end
            ST_ISSUE: begin
                if (hs) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (world_ant_q == IW'(N_ANTS - 1)) ? '0 : world_ant_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        budget_d = budget_q;
        if (ph_refill) begin
            budget_d = BW'(PH_BUDGET);
        end else if (hs && world_ph_q != '0 && budget_q != '0) begin
            budget_d = budget_q - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            world_ant_q  <= '0;
            world_move_q <= MOVE_HALT;
            world_ph_q   <= '0;
            budget_q     <= BW'(PH_BUDGET);
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            world_ant_q  <= world_ant_d;
            world_move_q <= world_move_d;
            world_ph_q   <= world_ph_d;
            budget_q     <= budget_d;
        end
    end

    for (genvar i = 0; i < N_ANTS; i++) begin : g_stall
        logic [SW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (hs && world_ant_q == IW'(i)) begin
                if (world_move_q == MOVE_HALT) begin
                    if (cnt_q != SW'(STALL_LIMIT)) cnt_d = cnt_q + SW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign stalled[i] = (cnt_q == SW'(STALL_LIMIT));
    end

endmodule

// File: tb/tb_ant_colony_arbiter.sv
// tb/tb_ant_colony_arbiter.sv - directed self-checking bench for ant_colony_arbiter
module tb_ant_colony_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] move_in;
    logic [7:0] ph_in;
    logic       ph_refill;
    logic [3:0] gnt;
    logic       world_valid;
    logic       world_ready;
    logic [1:0] world_ant;
    logic [1:0] world_move;
    logic [1:0] world_ph;
    logic [3:0] stalled;
    logic       ph_empty;

    int checks = 0;
    int errors = 0;

    ant_colony_arbiter #(
        .N_ANTS(4), .PH_WIDTH(2), .STALL_LIMIT(16), .PH_BUDGET(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .move_in     (move_in),
        .ph_in       (ph_in),
        .ph_refill   (ph_refill),
        .gnt         (gnt),
        .world_valid (world_valid),
        .world_ready (world_ready),
        .world_ant   (world_ant),
        .world_move  (world_move),
        .world_ph    (world_ph),
        .stalled     (stalled),
        .ph_empty    (ph_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; move_in = '0; ph_in = '0; ph_refill = 1'b0; world_ready = 1'b0;
        #12;
        chk("rst_valid",   32'(world_valid), 32'd0);
        chk("rst_gnt",     32'(gnt),         32'd0);
        chk("rst_ant",     32'(world_ant),   32'd0);
        chk("rst_move",    32'(world_move),  32'd0);
        chk("rst_ph",      32'(world_ph),    32'd0);
        chk("rst_stalled", 32'(stalled),     32'd0);
        chk("rst_ph_empty",32'(ph_empty),    32'd0);
        @(negedge clk); rst = 1'b0;

        // idle with no requests
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_valid", 32'(world_valid), 32'd0);
            chk("idle_gnt",   32'(gnt),         32'd0);
        end
        chk("idle_ph_empty", 32'(ph_empty), 32'd0);

        // all four requesting, ready high: strict rotation 0,1,2,3,0
        req = 4'b1111; move_in = 8'b01010101; world_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_valid", 32'(world_valid), 32'd1);
            chk("rr_ant",   32'(world_ant),   32'(k % 4));
            chk("rr_gnt",   32'(gnt),         32'(1 << (k % 4)));
            @(negedge clk);
            chk("rr_gap_valid", 32'(world_valid), 32'd0);
            chk("rr_gap_gnt",   32'(gnt),         32'd0);
            if (k == 4) req = 4'b0000;
        end

        // ant2 FORWARD with backpressure
        world_ready = 1'b0; req = 4'b0100; move_in = 8'b00110000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(world_valid), 32'd1);
            chk("bp_ant",   32'(world_ant),   32'd2);
            chk("bp_move",  32'(world_move),  32'd3);
            chk("bp_gnt",   32'(gnt),         32'd0);
        end
        world_ready = 1'b1; req = 4'b0000;
        #1;
        chk("bp_gnt_pulse", 32'(gnt), 32'h4);
        @(negedge clk);
        chk("bp_after_valid", 32'(world_valid), 32'd0);
        chk("bp_after_gnt",   32'(gnt),         32'd0);

        // ant1 HALT x16 then FORWARD
        req = 4'b0010; move_in = 8'b00000000;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("halt_gnt", 32'(gnt), 32'h2);
            @(negedge clk);
            chk("halt_stalled", 32'(stalled), (i == 16) ? 32'h2 : 32'h0);
        end
        move_in = 8'b00001100;
        @(negedge clk);
        chk("fwd_gnt",  32'(gnt),        32'h2);
        chk("fwd_move", 32'(world_move), 32'd3);
        @(negedge clk);
        chk("fwd_stalled_clear", 32'(stalled), 32'h0);
        req = 4'b0000;

        // pheromone budget exhaustion and refill
        @(negedge clk);
        req = 4'b0001; move_in = 8'b00000001; ph_in = 8'b00000001;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("ph_gnt",   32'(gnt),      32'h1);
            chk("ph_value", 32'(world_ph), (i <= 8) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk("ph_empty_flag", 32'(ph_empty), (i >= 8) ? 32'd1 : 32'd0);
            if (i == 10) req = 4'b0000;
        end
        ph_refill = 1'b1;
        @(negedge clk);
        ph_refill = 1'b0;
        chk("refill_ph_empty", 32'(ph_empty), 32'd0);
        req = 4'b0001;
        @(negedge clk);
        chk("refill_gnt", 32'(gnt),      32'h1);
        chk("refill_ph",  32'(world_ph), 32'd1);
        @(negedge clk);
        req = 4'b0000;

        // reset in the middle of an issue
        world_ready = 1'b0; req = 4'b1111;
        @(negedge clk);
        chk("pre_rst_valid", 32'(world_valid), 32'd1);
        chk("pre_rst_ant",   32'(world_ant),   32'd1);
        #2;
        rst = 1'b1; world_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(world_valid), 32'd0);
        chk("mid_rst_gnt",   32'(gnt),         32'd0);
        @(negedge clk);
        chk("hold_rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ant", 32'(world_ant), 32'd0);
        chk("post_rst_gnt", 32'(gnt),       32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
